// File: rtl/exec_controller.sv
// Run/halt/single-step sequencer with PC breakpoint, executed-cycle counter and data-memory arbitration.
// Latency: core_en and the memory mux are combinational; bp_hit and host_mem_ack appear one cycle after their cause.
// Backpressure: host_cmd_ready drops in STEP and MEM, and in HALT while a host memory request is pending.
//
// Ports:
//   CLK, reset                        - clock, synchronous active-high reset
//   host_cmd_valid/host_cmd/_data     - RUN/HALT/STEP/SETBP command channel, host_cmd_ready accepts
//   pc_in                             - current core PC, compared against the breakpoint
//   core_en, halted, bp_hit           - core progress gate and status
//   cycle_count                       - number of cycles with core_en=1 (wraps)
//   core_mem_*                        - core side of the data memory
//   host_mem_*                        - host debug access, serviced only while halted
//   mem_*                             - single-port data memory, 1-cycle read latency
module exec_controller #(
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 16,
    parameter int CNT_W         = 32,
    parameter int START_RUNNING = 0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              host_cmd_valid,
    input  logic [1:0]        host_cmd,
    input  logic [DATA_W-1:0] host_cmd_data,
    output logic              host_cmd_ready,
    input  logic [DATA_W-1:0] pc_in,
    output logic              core_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  cycle_count,
    input  logic [ADDR_W-1:0] core_mem_addr,
    input  logic              core_mem_we,
    input  logic [DATA_W-1:0] core_mem_wdata,
    input  logic              host_mem_req,
    input  logic              host_mem_we,
    input  logic [ADDR_W-1:0] host_mem_addr,
    input  logic [DATA_W-1:0] host_mem_wdata,
    output logic              host_mem_ack,
    output logic [DATA_W-1:0] host_mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_MEM  = 2'd3
    } state_t;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_HALT  = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_SETBP = 2'b11;

    localparam state_t RESET_STATE = (START_RUNNING != 0) ? S_RUN : S_HALT;

    state_t            state;
    state_t            state_nxt;
    logic              resume;
    logic              bp_en;
    logic [DATA_W-1:0] bp_pc;
    logic              mem_rd_q;
    logic              bp_match;
    logic              cmd_acc;
    logic              host_sel;

    // resume masks the breakpoint for the first cycle after a RUN/STEP so
    // the core can leave the PC it stopped on.
    assign bp_match = bp_en && (pc_in == bp_pc) && !resume;
    assign cmd_acc  = host_cmd_valid && host_cmd_ready;
    assign halted   = (state == S_HALT) || (state == S_MEM);

    // Reset overrides the combinational outputs too, so nothing advances,
    // writes or acknowledges while it is held.
    always_comb begin
        host_cmd_ready = 1'b0;
        core_en        = 1'b0;
        case (state)
            S_HALT: host_cmd_ready = !host_mem_req;
            S_RUN: begin
                host_cmd_ready = 1'b1;
                core_en        = !bp_match;
            end
            S_STEP: core_en = 1'b1;
            default: ;
        endcase
        if (reset) begin
            host_cmd_ready = 1'b0;
            core_en        = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HALT: begin
                if (host_mem_req) begin
                    state_nxt = S_MEM;
                end else if (cmd_acc && host_cmd == CMD_RUN) begin
                    state_nxt = S_RUN;
                end else if (cmd_acc && host_cmd == CMD_STEP) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                // A breakpoint and a HALT command in the same cycle both land in HALT.
                if (bp_match || (cmd_acc && host_cmd == CMD_HALT)) begin
                    state_nxt = S_HALT;
                end
            end
            S_STEP:  state_nxt = S_HALT;
            S_MEM:   state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    // Host owns the memory on the request cycle in HALT and for the
    // following MEM cycle; it only writes on the request cycle.
    always_comb begin
        host_sel = ((state == S_HALT) && host_mem_req) || (state == S_MEM);
        if (host_sel) begin
            mem_addr  = host_mem_addr;
            mem_wdata = host_mem_wdata;
            mem_we    = (state == S_HALT) && host_mem_we && !reset;
        end else begin
            mem_addr  = core_mem_addr;
            mem_wdata = core_mem_wdata;
            mem_we    = core_mem_we && core_en;
        end
    end

    assign host_mem_ack   = (state == S_MEM) && !reset;
    assign host_mem_rdata = (host_mem_ack && mem_rd_q) ? mem_rdata : '0;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= RESET_STATE;
            resume      <= 1'b0;
            bp_en       <= 1'b0;
            bp_pc       <= '0;
            cycle_count <= '0;
            bp_hit      <= 1'b0;
            mem_rd_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            bp_hit      <= (state == S_RUN) && bp_match;
            cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, core_en};

            if ((state == S_HALT) && host_mem_req) begin
                mem_rd_q <= !host_mem_we;
            end

            if (cmd_acc && (host_cmd == CMD_RUN || host_cmd == CMD_STEP)) begin
                resume <= 1'b1;
            end else if (state == S_RUN) begin
                resume <= 1'b0;
            end

            if (cmd_acc && host_cmd == CMD_SETBP) begin
                bp_en <= host_cmd_data[0];
                bp_pc <= {host_cmd_data[DATA_W-1:1], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: directed scenarios plus a randomized run against a
// behavioural model that tracks running/stepping/memory-access flags.
module tb_exec_controller;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 32;

    localparam logic [1:0] C_RUN   = 2'b00;
    localparam logic [1:0] C_HALT  = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_SETBP = 2'b11;

    logic              CLK = 1'b0;
    logic              reset;
    logic              host_cmd_valid;
    logic [1:0]        host_cmd;
    logic [DATA_W-1:0] host_cmd_data;
    logic              host_cmd_ready;
    logic [DATA_W-1:0] pc_in;
    logic              core_en;
    logic              halted;
    logic              bp_hit;
    logic [CNT_W-1:0]  cycle_count;
    logic [ADDR_W-1:0] core_mem_addr;
    logic              core_mem_we;
    logic [DATA_W-1:0] core_mem_wdata;
    logic              host_mem_req;
    logic              host_mem_we;
    logic [ADDR_W-1:0] host_mem_addr;
    logic [DATA_W-1:0] host_mem_wdata;
    logic              host_mem_ack;
    logic [DATA_W-1:0] host_mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always #5 CLK = ~CLK;

    exec_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .START_RUNNING(0)
    ) dut (
        .CLK(CLK), .reset(reset),
        .host_cmd_valid(host_cmd_valid), .host_cmd(host_cmd),
        .host_cmd_data(host_cmd_data), .host_cmd_ready(host_cmd_ready),
        .pc_in(pc_in), .core_en(core_en), .halted(halted), .bp_hit(bp_hit),
        .cycle_count(cycle_count),
        .core_mem_addr(core_mem_addr), .core_mem_we(core_mem_we), .core_mem_wdata(core_mem_wdata),
        .host_mem_req(host_mem_req), .host_mem_we(host_mem_we),
        .host_mem_addr(host_mem_addr), .host_mem_wdata(host_mem_wdata),
        .host_mem_ack(host_mem_ack), .host_mem_rdata(host_mem_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory attached to the DUT: 1-cycle registered read.
    logic              init_mem = 1'b1;
    logic [DATA_W-1:0] tb_mem [0:4095];
    always @(posedge CLK) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) tb_mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            mem_rdata <= tb_mem[mem_addr];
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit                m_running, m_stepping, m_in_mem, m_resume, m_bp_en, m_bp_hit, m_mem_read;
    logic [DATA_W-1:0] m_bp_pc;
    logic [CNT_W-1:0]  m_count;
    logic [ADDR_W-1:0] m_mem_addr;
    logic [DATA_W-1:0] ref_mem [0:4095];

    // Expected outputs for the current cycle
    bit                e_core_en, e_halted, e_ready, e_bp_hit, e_ack, e_mem_we, e_bp_match;
    logic [DATA_W-1:0] e_rdata, e_mem_wdata;
    logic [ADDR_W-1:0] e_mem_addr;
    logic [CNT_W-1:0]  e_count;

    task automatic model_eval();
        bit idle, host_now;
        idle       = !m_running && !m_stepping && !m_in_mem;
        e_bp_match = m_bp_en && (pc_in == m_bp_pc) && !m_resume;
        e_halted   = !m_running && !m_stepping;
        e_core_en  = !reset && (m_stepping || (m_running && !e_bp_match));
        e_ready    = !reset && (m_running || (idle && !host_mem_req));
        e_ack      = !reset && m_in_mem;
        e_rdata    = (e_ack && m_mem_read) ? ref_mem[m_mem_addr] : '0;
        host_now   = idle && host_mem_req;
        if (host_now || m_in_mem) begin
            e_mem_addr  = host_mem_addr;
            e_mem_wdata = host_mem_wdata;
            e_mem_we    = host_now && host_mem_we && !reset;
        end else begin
            e_mem_addr  = core_mem_addr;
            e_mem_wdata = core_mem_wdata;
            e_mem_we    = core_mem_we && e_core_en;
        end
        e_bp_hit = m_bp_hit;
        e_count  = m_count;
    endtask

    task automatic model_commit();
        bit acc;
        model_eval();
        if (reset) begin
            m_running = 1'b0; m_stepping = 1'b0; m_in_mem = 1'b0; m_resume = 1'b0;
            m_bp_en = 1'b0; m_bp_pc = '0; m_count = '0; m_bp_hit = 1'b0; m_mem_read = 1'b0;
        end else begin
            if (e_mem_we) ref_mem[e_mem_addr] = e_mem_wdata;
            if (e_core_en) m_count = m_count + 1;
            acc      = host_cmd_valid && e_ready;
            m_bp_hit = m_running && e_bp_match;
            if (acc && (host_cmd == C_RUN || host_cmd == C_STEP)) m_resume = 1'b1;
            else if (m_running) m_resume = 1'b0;
            if (acc && host_cmd == C_SETBP) begin
                m_bp_en = host_cmd_data[0];
                m_bp_pc = {host_cmd_data[DATA_W-1:1], 1'b0};
            end
            if (m_stepping) m_stepping = 1'b0;
            else if (m_in_mem) m_in_mem = 1'b0;
            else if (m_running) begin
                if (e_bp_match || (acc && host_cmd == C_HALT)) m_running = 1'b0;
            end else if (host_mem_req) begin
                m_in_mem   = 1'b1;
                m_mem_addr = host_mem_addr;
                m_mem_read = !host_mem_we;
            end else if (acc && host_cmd == C_RUN) m_running = 1'b1;
            else if (acc && host_cmd == C_STEP) m_stepping = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_commit();
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
        model_eval();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        init_mem = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL reset_halted: got %0b want 1", halted); end
        tests_run++; if (core_en !== 1'b0) begin tests_failed++; $display("FAIL reset_core_en: got %0b want 0", core_en); end
        tests_run++; if (cycle_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
        tests_run++; if (bp_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_bp_hit: got %0b want 0", bp_hit); end
        tests_run++; if (host_mem_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %0b want 0", host_mem_ack); end
        tests_run++; if (host_mem_rdata !== 16'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0000", host_mem_rdata); end
        tests_run++; if (host_cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %0b want 1", host_cmd_ready); end
        tick();
    endtask

    task automatic test_run_count();
        pc_in = 16'h0000;
        host_cmd_valid = 1'b1; host_cmd = C_RUN;
        settle();
        tests_run++; if (core_en !== 1'b0) begin tests_failed++; $display("FAIL run_accept_core_en: got %0b want 0", core_en); end
        tick();
        host_cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            tests_run++; if (core_en !== 1'b1) begin tests_failed++; $display("FAIL run_core_en[%0d]: got %0b want 1", i, core_en); end
            tick();
        end
        host_cmd_valid = 1'b1; host_cmd = C_HALT;
        settle();
        tests_run++; if (cycle_count !== 32'd10) begin tests_failed++; $display("FAIL run_count10: got %0d want 10", cycle_count); end
        tests_run++; if (core_en !== 1'b1) begin tests_failed++; $display("FAIL halt_accept_core_en: got %0b want 1", core_en); end
        tick();
        host_cmd_valid = 1'b0;
        settle();
        tests_run++; if (core_en !== 1'b0) begin tests_failed++; $display("FAIL halt_core_en: got %0b want 0", core_en); end
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL halt_halted: got %0b want 1", halted); end
        tests_run++; if (cycle_count !== 32'd11) begin tests_failed++; $display("FAIL halt_count: got %0d want 11", cycle_count); end
        tick();
    endtask

    task automatic test_breakpoint();
        int  hits;
        bit  adv;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        host_cmd_valid = 1'b1; host_cmd = C_SETBP; host_cmd_data = 16'h0021;
        tick();
        host_cmd = C_RUN;
        tick();
        host_cmd_valid = 1'b0;
        pc_in = 16'h0000;
        hits  = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            adv = core_en;
            tests_run++; if (core_en !== e_core_en) begin tests_failed++; $display("FAIL bp_core_en[%0d]: got %0b want %0b", i, core_en, e_core_en); end
            if (pc_in == 16'h0020) begin
                tests_run++; if (core_en !== 1'b0) begin tests_failed++; $display("FAIL bp_stop_at_pc: got %0b want 0", core_en); end
            end
            if (bp_hit === 1'b1) hits++;
            tick();
            if (adv) pc_in = pc_in + 16'd2;
        end
        settle();
        tests_run++; if (hits != 1) begin tests_failed++; $display("FAIL bp_hit_pulses: got %0d want 1", hits); end
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL bp_halted: got %0b want 1", halted); end
        tests_run++; if (cycle_count !== 32'd16) begin tests_failed++; $display("FAIL bp_count: got %0d want 16", cycle_count); end
        tests_run++; if (pc_in !== 16'h0020) begin tests_failed++; $display("FAIL bp_pc: got %h want 0020", pc_in); end
        tick();
    endtask

    task automatic test_step();
        host_cmd_valid = 1'b1; host_cmd = C_STEP;
        settle();
        tests_run++; if (host_cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL step_ready: got %0b want 1", host_cmd_ready); end
        tick();
        host_cmd_valid = 1'b0;
        settle();
        tests_run++; if (core_en !== 1'b1) begin tests_failed++; $display("FAIL step_core_en: got %0b want 1", core_en); end
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL step_halted: got %0b want 0", halted); end
        tests_run++; if (host_cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL step_busy_ready: got %0b want 0", host_cmd_ready); end
        tick();
        settle();
        tests_run++; if (core_en !== 1'b0) begin tests_failed++; $display("FAIL step_after_core_en: got %0b want 0", core_en); end
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL step_after_halted: got %0b want 1", halted); end
        tests_run++; if (cycle_count !== 32'd17) begin tests_failed++; $display("FAIL step_count: got %0d want 17", cycle_count); end
        tests_run++; if (bp_hit !== 1'b0) begin tests_failed++; $display("FAIL step_bp_hit: got %0b want 0", bp_hit); end
        tick();
    endtask

    task automatic test_host_mem();
        host_mem_req = 1'b1; host_mem_we = 1'b1; host_mem_addr = 12'h005; host_mem_wdata = 16'hBEEF;
        settle();
        tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL hw_mem_we: got %0b want 1", mem_we); end
        tests_run++; if (mem_addr !== 12'h005) begin tests_failed++; $display("FAIL hw_mem_addr: got %h want 005", mem_addr); end
        tests_run++; if (mem_wdata !== 16'hBEEF) begin tests_failed++; $display("FAIL hw_mem_wdata: got %h want beef", mem_wdata); end
        tests_run++; if (host_mem_ack !== 1'b0) begin tests_failed++; $display("FAIL hw_early_ack: got %0b want 0", host_mem_ack); end
        tests_run++; if (host_cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL hw_ready: got %0b want 0", host_cmd_ready); end
        tick();
        settle();
        tests_run++; if (host_mem_ack !== 1'b1) begin tests_failed++; $display("FAIL hw_ack: got %0b want 1", host_mem_ack); end
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL hw_we_once: got %0b want 0", mem_we); end
        tick();
        host_mem_req = 1'b0;
        settle();
        tests_run++; if (host_mem_ack !== 1'b0) begin tests_failed++; $display("FAIL hw_ack_once: got %0b want 0", host_mem_ack); end
        tick();
        host_mem_req = 1'b1; host_mem_we = 1'b0; host_mem_addr = 12'h005; host_mem_wdata = 16'h0000;
        settle();
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL hr_mem_we: got %0b want 0", mem_we); end
        tick();
        settle();
        tests_run++; if (host_mem_ack !== 1'b1) begin tests_failed++; $display("FAIL hr_ack: got %0b want 1", host_mem_ack); end
        tests_run++; if (host_mem_rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL hr_rdata: got %h want beef", host_mem_rdata); end
        tick();
        host_mem_req = 1'b0;
        settle();
        tests_run++; if (host_mem_ack !== 1'b0) begin tests_failed++; $display("FAIL hr_ack_once: got %0b want 0", host_mem_ack); end
        tick();
    endtask

    task automatic test_run_mem_block();
        pc_in = 16'h0100;
        host_cmd_valid = 1'b1; host_cmd = C_RUN;
        tick();
        host_cmd_valid = 1'b0;
        core_mem_we = 1'b1; core_mem_addr = 12'h010; core_mem_wdata = 16'h1234;
        host_mem_req = 1'b1; host_mem_we = 1'b0; host_mem_addr = 12'h005;
        for (int i = 0; i < 4; i++) begin
            settle();
            tests_run++; if (mem_addr !== 12'h010) begin tests_failed++; $display("FAIL rm_mem_addr[%0d]: got %h want 010", i, mem_addr); end
            tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL rm_mem_we[%0d]: got %0b want 1", i, mem_we); end
            tests_run++; if (host_mem_ack !== 1'b0) begin tests_failed++; $display("FAIL rm_no_ack[%0d]: got %0b want 0", i, host_mem_ack); end
            tick();
        end
        host_cmd_valid = 1'b1; host_cmd = C_HALT;
        settle();
        tests_run++; if (host_cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rm_halt_ready: got %0b want 1", host_cmd_ready); end
        tick();
        host_cmd_valid = 1'b0;
        settle();
        tests_run++; if (mem_addr !== 12'h005) begin tests_failed++; $display("FAIL rm_host_addr: got %h want 005", mem_addr); end
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rm_core_we_ignored: got %0b want 0", mem_we); end
        tick();
        settle();
        tests_run++; if (host_mem_ack !== 1'b1) begin tests_failed++; $display("FAIL rm_ack: got %0b want 1", host_mem_ack); end
        tests_run++; if (host_mem_rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL rm_rdata: got %h want beef", host_mem_rdata); end
        tick();
        host_mem_req = 1'b0;
        settle();
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rm_halted_we: got %0b want 0", mem_we); end
        tick();
        core_mem_we = 1'b0;
    endtask

    task automatic test_reset_in_mem();
        host_mem_req = 1'b1; host_mem_we = 1'b0; host_mem_addr = 12'h005;
        tick();
        reset = 1'b1;
        settle();
        tests_run++; if (host_mem_ack !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_ack: got %0b want 0", host_mem_ack); end
        tests_run++; if (host_mem_rdata !== 16'h0) begin tests_failed++; $display("FAIL rst_mem_rdata: got %h want 0000", host_mem_rdata); end
        tick();
        reset = 1'b0; host_mem_req = 1'b0;
        settle();
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL rst_mem_halted: got %0b want 1", halted); end
        tests_run++; if (cycle_count !== 32'd0) begin tests_failed++; $display("FAIL rst_mem_count: got %0d want 0", cycle_count); end
        tests_run++; if (host_mem_ack !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_late_ack: got %0b want 0", host_mem_ack); end
        tick();
        // Breakpoint at 0x0020 must be gone: running on that PC never stops.
        pc_in = 16'h0020;
        host_cmd_valid = 1'b1; host_cmd = C_RUN;
        tick();
        host_cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            tests_run++; if (core_en !== 1'b1) begin tests_failed++; $display("FAIL rst_bp_cleared[%0d]: got %0b want 1", i, core_en); end
            tick();
        end
        host_cmd_valid = 1'b1; host_cmd = C_HALT;
        tick();
        host_cmd_valid = 1'b0;
    endtask

    task automatic test_random();
        bit req_active = 1'b0;
        bit drop_req;
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 79) == 0);
            host_cmd_valid = ($urandom_range(0, 9) < 3);
            host_cmd       = 2'($urandom_range(0, 3));
            host_cmd_data  = 16'({$urandom_range(0, 15), 1'b0}) | 16'($urandom_range(0, 1));
            pc_in          = 16'($urandom_range(0, 15) * 2);
            core_mem_we    = 1'($urandom_range(0, 1));
            core_mem_addr  = 12'($urandom_range(0, 15));
            core_mem_wdata = 16'($urandom);
            if (!req_active && $urandom_range(0, 3) == 0) begin
                req_active     = 1'b1;
                host_mem_we    = 1'($urandom_range(0, 1));
                host_mem_addr  = 12'($urandom_range(0, 15));
                host_mem_wdata = 16'($urandom);
            end
            host_mem_req = req_active;
            settle();
            tests_run++; if (core_en !== e_core_en) begin tests_failed++; $display("FAIL rnd_core_en[%0d]: got %0b want %0b", i, core_en, e_core_en); end
            tests_run++; if (halted !== e_halted) begin tests_failed++; $display("FAIL rnd_halted[%0d]: got %0b want %0b", i, halted, e_halted); end
            tests_run++; if (host_cmd_ready !== e_ready) begin tests_failed++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, host_cmd_ready, e_ready); end
            tests_run++; if (bp_hit !== e_bp_hit) begin tests_failed++; $display("FAIL rnd_bp_hit[%0d]: got %0b want %0b", i, bp_hit, e_bp_hit); end
            tests_run++; if (cycle_count !== e_count) begin tests_failed++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, cycle_count, e_count); end
            tests_run++; if (host_mem_ack !== e_ack) begin tests_failed++; $display("FAIL rnd_ack[%0d]: got %0b want %0b", i, host_mem_ack, e_ack); end
            tests_run++; if (host_mem_rdata !== e_rdata) begin tests_failed++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, host_mem_rdata, e_rdata); end
            tests_run++; if (mem_addr !== e_mem_addr) begin tests_failed++; $display("FAIL rnd_mem_addr[%0d]: got %h want %h", i, mem_addr, e_mem_addr); end
            tests_run++; if (mem_we !== e_mem_we) begin tests_failed++; $display("FAIL rnd_mem_we[%0d]: got %0b want %0b", i, mem_we, e_mem_we); end
            tests_run++; if (mem_wdata !== e_mem_wdata) begin tests_failed++; $display("FAIL rnd_mem_wdata[%0d]: got %h want %h", i, mem_wdata, e_mem_wdata); end
            drop_req = e_ack;
            tick();
            if (drop_req) req_active = 1'b0;
        end
        reset = 1'b0; host_cmd_valid = 1'b0; host_mem_req = 1'b0; core_mem_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; host_cmd_valid = 1'b0; host_cmd = 2'b00; host_cmd_data = '0;
        pc_in = '0; core_mem_addr = '0; core_mem_we = 1'b0; core_mem_wdata = '0;
        host_mem_req = 1'b0; host_mem_we = 1'b0; host_mem_addr = '0; host_mem_wdata = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        test_reset();
        test_run_count();
        test_breakpoint();
        test_step();
        test_host_mem();
        test_run_mem_block();
        test_reset_in_mem();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within 1000000 time units");
        $fatal(1);
    end

endmodule

// File: doc/exec_controller.md
Name: exec_controller

Overview:
- Run/halt/single-step sequencer for the stack processor core, with a PC breakpoint and a cycle counter.
- Gates core progress (PC write, stack, return stack and data-memory write enables) through one `core_en` output.
- Arbitrates the single-port 12-bit-address data memory between the core and a host debug port; the host is granted access only while the core is halted.
- Sits between the core datapath/control and the board-level host interface.

Parameters:
- ADDR_W, 12, data memory word-address width (matches the word address derived from the shifted immediate).
- DATA_W, 16, data/PC width.
- CNT_W, 32, width of the executed-cycle counter.
- START_RUNNING, 0, if 1 the state after reset is RUN instead of HALT.

Ports:
- CLK  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- host_cmd_valid  in  1  host command strobe.
- host_cmd  in  2  00 RUN, 01 HALT, 10 STEP, 11 SETBP.
- host_cmd_data  in  DATA_W  SETBP operand: bit0 = breakpoint enable, [15:1] = breakpoint PC[15:1].
- host_cmd_ready  out  1  command accepted when valid && ready.
- pc_in  in  DATA_W  current core PC (register output).
- core_en  out  1  core may advance this cycle.
- halted  out  1  state is HALT or MEM.
- bp_hit  out  1  one-cycle pulse when a breakpoint stops the core.
- cycle_count  out  CNT_W  count of cycles with core_en=1.
- core_mem_addr  in  ADDR_W  core data-memory address.
- core_mem_we  in  1  core data-memory write enable.
- core_mem_wdata  in  DATA_W  core data-memory write data.
- host_mem_req  in  1  host memory access request; held until ack.
- host_mem_we  in  1  1 = write, 0 = read.
- host_mem_addr  in  ADDR_W  host address.
- host_mem_wdata  in  DATA_W  host write data.
- host_mem_ack  out  1  one-cycle completion pulse.
- host_mem_rdata  out  DATA_W  read data, valid while host_mem_ack=1.
- mem_addr  out  ADDR_W  to data memory.
- mem_we  out  1  to data memory.
- mem_wdata  out  DATA_W  to data memory.
- mem_rdata  in  DATA_W  from data memory; 1-cycle read latency.

Behaviour:
- States are HALT, RUN, STEP and MEM.
- Reset (synchronous, overrides everything, including mid-MEM or mid-STEP):
  - state = HALT, or RUN if START_RUNNING=1.
  - cycle_count = 0, bp_en = 0, bp_addr = 0.
  - bp_hit = 0, host_mem_ack = 0, host_mem_rdata = 0.
  - Any pending ack is dropped.
- core_en is combinational:
  - 1 in STEP.
  - 1 in RUN unless bp_match.
  - 0 in HALT and MEM.
  - bp_match = bp_en && pc_in == {bp_addr[15:1], 0} && !resume.
- resume is a register:
  - Set on the cycle a RUN or STEP command is accepted.
  - Cleared after the first RUN cycle.
  - Purpose: the core can resume from the breakpoint PC without re-hitting it.
- host_cmd_ready = 1 in HALT and RUN, 0 in STEP and MEM.
  - Also 0 in HALT on a cycle where host_mem_req=1; memory has priority.
- HALT transitions:
  - RUN command -> RUN.
  - STEP command -> STEP.
  - host_mem_req -> MEM.
  - HALT command accepted, no effect.
- STEP lasts exactly one cycle (core_en=1), then returns to HALT.
- RUN transitions:
  - HALT command -> HALT. core_en stays 1 during the acceptance cycle, 0 from the next cycle.
  - bp_match -> HALT, with bp_hit=1 registered for the next cycle. The instruction at the breakpoint PC does not execute.
  - bp_match and a HALT command in the same cycle: HALT, and bp_hit still pulses.
- SETBP is accepted in HALT or RUN and causes no state change.
  - bp_en = data[0], bp_addr = data[15:1].
  - Takes effect from the next cycle.
- cycle_count increments by 1 on each cycle with core_en=1 and wraps modulo 2^CNT_W.
- Memory mux:
  - In HALT with host_mem_req, and in MEM, mem_* is driven from host_mem_*.
  - Otherwise mem_addr = core_mem_addr, mem_wdata = core_mem_wdata, mem_we = core_mem_we && core_en. A stalled core never writes.
- Host memory access (HALT with host_mem_req, cycle T):
  - Address, we and wdata are presented at T; the block goes to MEM.
  - In MEM at T+1: host_mem_ack=1; for a read, host_mem_rdata = mem_rdata.
  - MEM returns to HALT at T+2.
  - mem_we is 1 only at T.
- host_mem_req in RUN or STEP is not serviced; it waits, with no ack, until HALT.

Test Plan:
- Reset -> halted=1, core_en=0, cycle_count=0. Then RUN cmd -> core_en=1 from the next cycle; after 10 run cycles cycle_count=10.
- SETBP data=0x0021 (bp 0x0020, enabled), RUN, pc_in steps by 2 from 0 -> core_en=0 in the cycle pc_in=0x0020, bp_hit pulses once, halted=1, cycle_count=16.
- From the breakpoint halt, STEP -> exactly one core_en cycle with pc_in=0x0020 (no re-hit), then halted; cycle_count=17.
- Halted: host write addr 0x005 data 0xBEEF -> mem_we for 1 cycle, ack next cycle. Host read 0x005 -> ack with rdata=0xBEEF at T+1.
- RUN with core_mem_we=1, host_mem_req=1 -> memory follows the core, no ack. HALT cmd -> host served; core_mem_we ignored while halted.
- Reset asserted in MEM during a read -> no ack, state HALT, bp_en=0, cycle_count=0.
